// File: rtl/cla_seq_arbiter_pkg.sv
// rtl/cla_seq_arbiter_pkg.sv - shared types and constants for the nibble-serial CLA arbiter
// Contents:
//   NIBBLE_W   width of the shared carry-lookahead slice
//   MAX_WIDTH  widest operand the response struct can carry
//   state_t    sequencer states (IDLE, RUN, DONE)
//   rsp_t      response bundle (id, sum, cout, ovf)
//   pick_grant round-robin tie-break between the two requesters

package cla_seq_arbiter_pkg;

   localparam int NIBBLE_W  = 4;
   localparam int MAX_WIDTH = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // The sum field is sized for the widest supported operand; narrower
   // instances zero-extend into it and slice back out.
   typedef struct packed {
      logic                 id;
      logic [MAX_WIDTH-1:0] sum;
      logic                 cout;
      logic                 ovf;
   } rsp_t;

   // Requester index that wins when at least one request is valid.
   // With both valid the round-robin pointer decides; otherwise the
   // single valid requester wins (returns 0 when neither is valid, the
   // caller qualifies with the OR of the valids).
   function automatic logic pick_grant(input logic v0, input logic v1, input logic rr);
      return (v0 && v1) ? rr : v1;
   endfunction

endpackage

// File: rtl/cla_seq_arbiter_cla4_slice.sv
// rtl/cla_seq_arbiter_cla4_slice.sv - combinational 4-bit carry-lookahead adder slice
// Ports:
//   a, b    nibble operands
//   cin     carry into bit 0
//   sum     nibble sum
//   c4      carry out of bit 3
//   grp_p   group propagate (all four bits propagate)
//   grp_g   group generate (the nibble generates a carry on its own)

module cla4_slice
   import cla_seq_arbiter_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                c4,
   output logic                grp_p,
   output logic                grp_g
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   // Inclusive-OR propagate: still correct for carries, and the sum uses a^b
   // directly so the choice of propagate does not affect it.
   assign g = a & b;
   assign p = a | b;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);

   assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
   assign grp_p = &p;
   assign c[4]  = grp_g | (grp_p & cin);

   assign sum = a ^ b ^ c[3:0];
   assign c4  = c[4];

endmodule

// File: rtl/cla_seq_arbiter.sv
// rtl/cla_seq_arbiter.sv - two-requester round-robin sequencer for a nibble-serial CLA add/sub
// Ports:
//   clk, rst_n                   clock (rising edge), asynchronous active-low reset
//   req0_valid/ready/a/b/sub     requester 0 operation handshake and operands
//   req1_valid/ready/a/b/sub     requester 1 operation handshake and operands
//   rsp_valid, rsp_ready         result handshake
//   rsp_id                       index of the requester the result belongs to
//   rsp_sum, rsp_cout, rsp_ovf   result, carry out (sub: 1 = no borrow), signed overflow
// WIDTH must be a multiple of 4, at least 4 and no wider than MAX_WIDTH.

module cla_seq_arbiter
   import cla_seq_arbiter_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_sub,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_sub,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_cout,
   output logic             rsp_ovf
);

   localparam int NNIB  = WIDTH / NIBBLE_W;
   localparam int IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NNIB - 1);

   state_t           state;
   state_t           state_nx;
   logic             rr;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;      // already inverted for subtraction
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic [IDX_W-1:0] idx_q;
   logic             id_q;

   logic             any_req;
   logic             grant;
   logic             accept;
   logic             rsp_fire;
   logic             last_nib;

   logic [NIBBLE_W-1:0] nib_a;
   logic [NIBBLE_W-1:0] nib_b;
   logic [NIBBLE_W-1:0] nib_sum;
   logic                nib_c4;
   logic                grp_p;
   logic                grp_g;

   rsp_t             rsp_pack;
   logic             unused_bits;

   // ------------------------------------------------------------------
   // Arbitration and handshakes
   // ------------------------------------------------------------------
   // Readies are gated by rst_n so nothing looks accepted while reset is
   // asserted, even though the state register already reads IDLE.
   always_comb begin
      any_req    = req0_valid | req1_valid;
      grant      = pick_grant(req0_valid, req1_valid, rr);
      accept     = rst_n && (state == IDLE) && any_req;
      req0_ready = accept && !grant;
      req1_ready = accept &&  grant;
      rsp_fire   = (state == DONE) && rsp_ready;
      last_nib   = (idx_q == LAST_IDX);
   end

   // ------------------------------------------------------------------
   // Sequencer FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = RUN;
            end
         end
         RUN: begin
            if (last_nib) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Shared slice: nibble select from the captured operands
   // ------------------------------------------------------------------
   always_comb begin
      nib_a = '0;
      nib_b = '0;
      for (int n = 0; n < NNIB; n++) begin
         if (idx_q == IDX_W'(n)) begin
            nib_a = a_q[n*NIBBLE_W +: NIBBLE_W];
            nib_b = b_q[n*NIBBLE_W +: NIBBLE_W];
         end
      end
   end

   cla4_slice u_slice (
      .a     (nib_a),
      .b     (nib_b),
      .cin   (carry_q),
      .sum   (nib_sum),
      .c4    (nib_c4),
      .grp_p (grp_p),
      .grp_g (grp_g)
   );

   // ------------------------------------------------------------------
   // Operand capture, nibble iteration and round-robin pointer
   // ------------------------------------------------------------------
   // Subtraction is A + ~B + 1: invert B at capture and seed the carry with
   // the sub flag, so the RUN loop is identical for both operations.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         id_q    <= 1'b0;
         rr      <= 1'b0;
      end else begin
         if (accept) begin
            if (grant) begin
               a_q     <= req1_a;
               b_q     <= req1_sub ? ~req1_b : req1_b;
               carry_q <= req1_sub;
            end else begin
               a_q     <= req0_a;
               b_q     <= req0_sub ? ~req0_b : req0_b;
               carry_q <= req0_sub;
            end
            idx_q <= '0;
            id_q  <= grant;
         end else if (state == RUN) begin
            for (int n = 0; n < NNIB; n++) begin
               if (idx_q == IDX_W'(n)) begin
                  sum_q[n*NIBBLE_W +: NIBBLE_W] <= nib_sum;
               end
            end
            carry_q <= nib_c4;
            idx_q   <= idx_q + IDX_W'(1);
         end

         // The requester just served loses the next tie.
         if (rsp_fire) begin
            rr <= ~id_q;
         end
      end
   end

   // ------------------------------------------------------------------
   // Response
   // ------------------------------------------------------------------
   // Overflow: operands (after the B inversion) agree in sign but the
   // result sign differs. All terms are registers, so the response stays
   // stable while DONE waits on rsp_ready.
   always_comb begin
      rsp_pack.id   = id_q;
      rsp_pack.sum  = MAX_WIDTH'(sum_q);
      rsp_pack.cout = carry_q;
      rsp_pack.ovf  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);
   end

   assign rsp_id   = rsp_pack.id;
   assign rsp_sum  = rsp_pack.sum[WIDTH-1:0];
   assign rsp_cout = rsp_pack.cout;
   assign rsp_ovf  = rsp_pack.ovf;

   // Group P/G and the struct's headroom bits are not needed by a serial
   // nibble loop.
   assign unused_bits = (^(rsp_pack.sum >> WIDTH)) ^ grp_p ^ grp_g;

endmodule

// File: tb/tb_cla_seq_arbiter.sv
// tb/tb_cla_seq_arbiter.sv - scoreboard bench for cla_seq_arbiter at WIDTH=16

module tb_cla_seq_arbiter;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0_valid, req0_ready, req0_sub;
   logic [W-1:0] req0_a, req0_b;
   logic         req1_valid, req1_ready, req1_sub;
   logic [W-1:0] req1_a, req1_b;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
   logic [W-1:0] rsp_sum;

   typedef struct packed {
      logic         id;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   exp_t sb_q[$];
   int   grant_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   cla_seq_arbiter #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_sub   (req0_sub),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_sub   (req1_sub),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_sum    (rsp_sum),
      .rsp_cout   (rsp_cout),
      .rsp_ovf    (rsp_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic id, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic sub);
      logic [W-1:0] bp;
      logic [W:0]   t;
      exp_t         e;
      bp     = sub ? ~b : b;
      t      = {1'b0, a} + {1'b0, bp} + (W+1)'(sub);
      e.id   = id;
      e.sum  = t[W-1:0];
      e.cout = t[W];
      e.ovf  = (a[W-1] == bp[W-1]) && (t[W-1] != a[W-1]);
      return e;
   endfunction

   // Monitor: push expectations on accepted requests, pop on delivered results.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
      end else begin
         chk("one_ready", 32'(req0_ready & req1_ready), 32'd0);
         if (req0_valid && req0_ready) begin
            sb_q.push_back(model(1'b0, req0_a, req0_b, req0_sub));
            grant_q.push_back(0);
         end
         if (req1_valid && req1_ready) begin
            sb_q.push_back(model(1'b1, req1_a, req1_b, req1_sub));
            grant_q.push_back(1);
         end
         if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
               chk("sb_underflow", 32'd1, 32'd0);
            end else begin
               mon_e = sb_q.pop_front();
               chk("rsp_id",   32'(rsp_id),   32'(mon_e.id));
               chk("rsp_sum",  32'(rsp_sum),  32'(mon_e.sum));
               chk("rsp_cout", 32'(rsp_cout), 32'(mon_e.cout));
               chk("rsp_ovf",  32'(rsp_ovf),  32'(mon_e.ovf));
            end
         end
      end
   end

   task automatic send(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      logic got;
      if (r == 0) begin
         req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
      end else begin
         req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
      end
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         got = (r == 0) ? req0_ready : req1_ready;
      end
      chk("accept_wait", 32'(got), 32'd1);
      @(posedge clk);
      #1;
      if (r == 0) req0_valid = 1'b0;
      else        req1_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         if (sb_q.size() == 0) break;
      end
      #1;
      chk("drain", 32'(sb_q.size()), 32'd0);
   endtask

   // Waits (bounded) until n grants have been logged; returns at the
   // accepting edge + 1 so the caller can drop the matching valid.
   task automatic wait_grants(input int n);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         if (grant_q.size() >= n) break;
      end
      #1;
      chk("grant_wait", 32'(grant_q.size() >= n), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int   cyc;
      logic rv;

      rst_n      = 1'b0;
      req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222; req0_sub = 1'b0;
      req1_valid = 1'b1; req1_a = 16'h3333; req1_b = 16'h4444; req1_sub = 1'b0;
      rsp_ready  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid),  32'd0);
      chk("rst_rsp_sum",   32'(rsp_sum),    32'd0);
      chk("rst_rsp_cout",  32'(rsp_cout),   32'd0);
      chk("rst_rsp_ovf",   32'(rsp_ovf),    32'd0);
      chk("rst_rsp_id",    32'(rsp_id),     32'd0);
      chk("rst_req0_rdy",  32'(req0_ready), 32'd0);
      chk("rst_req1_rdy",  32'(req1_ready), 32'd0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Add with latency measurement
      send(0, 16'h1234, 16'h0FFF, 1'b0);
      cyc = 0;
      rv  = 1'b0;
      for (int i = 0; i < 20 && !rv; i++) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         rv = rsp_valid;
      end
      chk("latency", 32'(cyc), 32'd4);
      drain();

      // Subtract and carry/overflow boundaries
      send(1, 16'h0005, 16'h0007, 1'b1);
      send(1, 16'h0007, 16'h0005, 1'b1);
      send(0, 16'hFFFF, 16'h0001, 1'b0);
      send(1, 16'h7FFF, 16'h0001, 1'b0);
      send(0, 16'h8000, 16'h0001, 1'b1);
      drain();

      // Both requesters valid from reset: grants must alternate 0,1,0,1
      rst_n = 1'b0;
      req0_a = 16'h0101; req0_b = 16'h0202; req0_sub = 1'b0; req0_valid = 1'b1;
      req1_a = 16'h0500; req1_b = 16'h0100; req1_sub = 1'b1; req1_valid = 1'b1;
      grant_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      wait_grants(4);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("grant_seq", (i < grant_q.size()) ? 32'(grant_q[i]) : 32'd99, 32'(i % 2));
      end
      drain();

      // Backpressure in DONE with a competing request held
      rsp_ready = 1'b0;
      send(0, 16'h1111, 16'h2222, 1'b0);
      req1_a = 16'h0F0F; req1_b = 16'h00F0; req1_sub = 1'b0; req1_valid = 1'b1;
      rv = 1'b0;
      for (int i = 0; i < 20 && !rv; i++) begin
         @(negedge clk);
         rv = rsp_valid;
      end
      for (int k = 0; k < 3; k++) begin
         chk("bp_valid",  32'(rsp_valid),  32'd1);
         chk("bp_sum",    32'(rsp_sum),    32'h3333);
         chk("bp_cout",   32'(rsp_cout),   32'd0);
         chk("bp_id",     32'(rsp_id),     32'd0);
         chk("bp_r0_rdy", 32'(req0_ready), 32'd0);
         chk("bp_r1_rdy", 32'(req1_ready), 32'd0);
         if (k < 2) @(negedge clk);
      end
      @(posedge clk);
      #1;
      rsp_ready  = 1'b1;
      req1_valid = 1'b0;
      drain();

      // Reset after two RUN cycles abandons the transaction
      send(0, 16'h1234, 16'h1111, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      req0_a = 16'h0010; req0_b = 16'h0020; req0_sub = 1'b0; req0_valid = 1'b1;
      req1_a = 16'h00FF; req1_b = 16'h0001; req1_sub = 1'b0; req1_valid = 1'b1;
      #1;
      chk("mid_rst_valid",   32'(rsp_valid),  32'd0);
      chk("mid_rst_r0_rdy",  32'(req0_ready), 32'd0);
      chk("mid_rst_r1_rdy",  32'(req1_ready), 32'd0);
      grant_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      wait_grants(1);
      req0_valid = 1'b0;
      wait_grants(2);
      req1_valid = 1'b0;
      chk("post_rst_grant0", (grant_q.size() > 0) ? 32'(grant_q[0]) : 32'd99, 32'd0);
      chk("post_rst_grant1", (grant_q.size() > 1) ? 32'(grant_q[1]) : 32'd99, 32'd1);
      drain();

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
